sd_spi_host: RTL and testbench
==============================

// Module: sd_spi_host
// PURPOSE
//  SPI-mode SD host command engine: drives sdCS/sdSCLK/sdMOSI, samples sdMISO.
//  Sends one 6-byte SD command frame, polls for the R1 response, optionally reads a
//  4-byte R3/R7 tail or a 512-byte single-block read (token 0xFE, data, 2 CRC bytes).
//  Sits between the RK8E disk controller sequencer and the SD card (sdsim in simulation).
// PARAMETERS
//  CLKDIV     4     clk cycles per sdSCLK half-period (>=2)
//  RSP_POLL   8     max 0xFF bytes clocked while waiting for R1
//  TOK_POLL   1024  max bytes clocked while waiting for the data start token
// PORTS
//  clk       in   1   system clock
//  reset     in   1   asynchronous, active-high reset
//  start     in   1   1-cycle request; sampled only when busy=0
//  cmd       in   6   SD command index
//  arg       in   32  command argument, sent MSB first
//  crc       in   7   CRC7 for the frame
//  rsp_type  in   2   0=R1, 1=R1+4 bytes (R3/R7), 2=R1+512-byte read block, 3=reserved (as 0)
//  busy      out  1   operation in progress
//  done      out  1   1-cycle pulse at end of operation
//  err       out  3   0 ok,1 R1 timeout,2 token timeout,3 data error token,4 R1!=0 on read
//  r1        out  8   captured R1 byte
//  rsp_data  out  32  captured R3/R7 bytes, first byte in [31:24]
//  rd_data   out  8   read-block data byte
//  rd_valid  out  1   1-cycle strobe per rd_data byte (exactly 512 per good read)
//  sdCS      out  1   chip select, active low
//  sdSCLK    out  1   SPI clock, idle low (mode 0)
//  sdMOSI    out  1   SPI data out, idle high
//  sdMISO    in   1   SPI data in
// BEHAVIOUR
//  Reset (async): sdCS=1, sdSCLK=0, sdMOSI=1, busy=0, done=0, rd_valid=0, err=0, r1=8'hFF,
//   rsp_data=0, rd_data=0, FSM=IDLE; takes effect mid-transfer, no tail clocks issued.
//  Byte engine: mode 0, MSB first. MOSI updated on SCLK falling edge (first bit set before
//   first rise), MISO sampled on rising edge. Byte = 8 SCLK periods = 16*CLKDIV clk.
//   Bytes are back-to-back with no idle gap; sdMOSI=1 whenever no command byte is sent.
//  FSM: IDLE -> CMD -> RSP -> {EXT | TOKEN -> DATA -> CRC} -> TAIL -> IDLE.
//   IDLE : start&!busy latches cmd/arg/crc/rsp_type; busy=1 next cycle, sdCS=0.
//   CMD  : sends {2'b01,cmd}, arg[31:24]..arg[7:0], {crc,1'b1}.
//   RSP  : clocks 0xFF; first byte with bit7=0 -> r1. None within RSP_POLL -> err=1, TAIL.
//          rsp_type=1 -> EXT; rsp_type=2 and r1!=0 -> err=4, TAIL; rsp_type=2 -> TOKEN;
//          else TAIL.
//   EXT  : 4 bytes shifted into rsp_data.
//   TOKEN: 0xFF ignored; 0xFE -> DATA; any other byte with bits[7:4]=0 -> err=3, TAIL;
//          TOK_POLL bytes without token -> err=2, TAIL.
//   DATA : 512 bytes; rd_data valid with rd_valid for 1 clk after each 8th rising edge.
//   CRC  : 2 bytes clocked and discarded (no CRC check).
//   TAIL : sdCS=1, one 0xFF byte (8 clocks) with CS high, then done=1 for 1 clk, busy=0
//          in the same cycle as done; err/r1/rsp_data hold until next start.
//  start while busy=1 is ignored (not queued). err cleared to 0 on accepted start.
//  Byte/poll counters saturate cleanly; 512-byte counter is 10 bits, no wrap reuse.
// TESTING
//  CMD0 arg=0 crc=7'h4A type0 vs sdsim -> MOSI 40 00 00 00 00 95, r1=01, err=0, done once.
//  CMD8 arg=32'h1AA crc=7'h43 type1 -> r1=01, rsp_data=32'h000001AA, err=0.
//  CMD17 arg=0 type2 -> 512 rd_valid pulses, bytes equal image[0..511], err=0, sdCS high after.
//  sdMISO tied 1, CMD55 -> exactly RSP_POLL poll bytes, err=1, r1=FF, done pulse.
//  reset asserted mid-DATA (byte 100) -> sdCS=1, sdSCLK=0, busy=0 same cycle; next CMD0 ok.
//  start pulsed while busy, and SCLK period check -> ignored; SCLK period = 2*CLKDIV clk.

Source files
------------

// File: rtl/sd_spi_host.sv
// sd_spi_host -- SPI-mode SD card command engine.
// Sends one 6-byte command frame, polls for R1, then optionally reads a
// 4-byte R3/R7 tail or a 512-byte single data block. It closes every
// operation with one 0xFF byte clocked while chip select is high.
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   start               request, accepted only while idle
//   cmd/arg/crc         command index, argument (MSB first), CRC7
//   rsp_type            0 R1, 1 R1+4 bytes, 2 R1+read block, 3 as 0
//   busy/done/err       status; done pulses once when busy drops
//   r1/rsp_data         captured response bytes
//   rd_data/rd_valid    read-block byte stream
//   sdCS/sdSCLK/sdMOSI  SPI outputs (mode 0); sdMISO SPI input
module sd_spi_host #(
  parameter int CLKDIV   = 4,
  parameter int RSP_POLL = 8,
  parameter int TOK_POLL = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  cmd,
  input  logic [31:0] arg,
  input  logic [6:0]  crc,
  input  logic [1:0]  rsp_type,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err,
  output logic [7:0]  r1,
  output logic [31:0] rsp_data,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        sdCS,
  output logic        sdSCLK,
  output logic        sdMOSI,
  input  logic        sdMISO
);

  localparam int DIV_W = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
  localparam int CNT_W = (TOK_POLL > 1024) ? $clog2(TOK_POLL) : 10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_RSP, ST_EXT, ST_TOKEN, ST_DATA, ST_CRC, ST_TAIL
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [5:0]         cmd_r;
  logic [31:0]        arg_r;
  logic [6:0]         crc_r;
  logic [1:0]         type_r;
  logic               xfer_r;
  logic [DIV_W-1:0]   div_r;
  logic [3:0]         half_r;
  logic [7:0]         tx_r, rx_r;
  logic               tick_s, byte_done_s, load_s, latch_s;
  logic [7:0]         load_byte_s;
  logic               busy_s, done_s, cs_s, rd_valid_s;
  logic [2:0]         err_s;
  logic [7:0]         r1_s, rd_data_s;
  logic [31:0]        rsp_data_s;

  // Byte idx of the command frame: start/transmission bits + index, arg, CRC + end bit.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [5:0] c,
                                            input logic [31:0] a, input logic [6:0] k);
    case (idx)
      3'd0:    frame_byte = {2'b01, c};
      3'd1:    frame_byte = a[31:24];
      3'd2:    frame_byte = a[23:16];
      3'd3:    frame_byte = a[15:8];
      3'd4:    frame_byte = a[7:0];
      3'd5:    frame_byte = {k, 1'b1};
      default: frame_byte = 8'hFF;
    endcase
  endfunction

  // One tick per SCLK half-period; half_r counts 16 halves per byte.
  assign tick_s      = xfer_r && (div_r == DIV_W'(CLKDIV - 1));
  assign byte_done_s = tick_s && (half_r == 4'd15);

  // SPI byte engine: rising half samples MISO, falling half shifts MOSI.
  // A load in the byte-done cycle makes that falling edge present the next
  // byte's MSB, so bytes run back-to-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xfer_r <= 1'b0;
      div_r  <= {DIV_W{1'b0}};
      half_r <= 4'd0;
      sdSCLK <= 1'b0;
      sdMOSI <= 1'b1;
      tx_r   <= 8'hFF;
      rx_r   <= 8'hFF;
    end else if (load_s) begin
      xfer_r <= 1'b1;
      div_r  <= {DIV_W{1'b0}};
      half_r <= 4'd0;
      sdSCLK <= 1'b0;
      tx_r   <= load_byte_s;
      sdMOSI <= load_byte_s[7];
    end else if (tick_s) begin
      div_r  <= {DIV_W{1'b0}};
      half_r <= half_r + 4'd1;
      if (!half_r[0]) begin
        sdSCLK <= 1'b1;
        rx_r   <= {rx_r[6:0], sdMISO};
      end else if (half_r == 4'd15) begin
        sdSCLK <= 1'b0;
        xfer_r <= 1'b0;
        sdMOSI <= 1'b1;
      end else begin
        sdSCLK <= 1'b0;
        tx_r   <= {tx_r[6:0], 1'b1};
        sdMOSI <= tx_r[6];
      end
    end else if (xfer_r) begin
      div_r <= div_r + DIV_W'(1);
    end else begin
      div_r <= {DIV_W{1'b0}};
    end
  end

  // Next-state and output decode; every non-final byte reloads 0xFF by default.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    busy_s      = busy;
    done_s      = 1'b0;
    cs_s        = sdCS;
    err_s       = err;
    r1_s        = r1;
    rsp_data_s  = rsp_data;
    rd_data_s   = rd_data;
    rd_valid_s  = 1'b0;
    load_s      = 1'b0;
    load_byte_s = 8'hFF;
    latch_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          latch_s     = 1'b1;
          load_s      = 1'b1;
          load_byte_s = frame_byte(3'd0, cmd, arg, crc);
          state_s     = ST_CMD;
          cnt_s       = {CNT_W{1'b0}};
          busy_s      = 1'b1;
          cs_s        = 1'b0;
          err_s       = 3'd0;
          r1_s        = 8'hFF;
          rsp_data_s  = 32'h0000_0000;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_TAIL: begin
        if (byte_done_s) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
          busy_s  = 1'b0;
        end else begin
          state_s = ST_TAIL;
        end
      end
      default: begin
        if (byte_done_s) begin
          load_s = 1'b1;
          cnt_s  = cnt_r + CNT_W'(1);
          case (state_r)
            ST_CMD: begin
              if (cnt_r == CNT_W'(5)) begin
                state_s = ST_RSP;
                cnt_s   = {CNT_W{1'b0}};
              end else begin
                load_byte_s = frame_byte(cnt_r[2:0] + 3'd1, cmd_r, arg_r, crc_r);
              end
            end
            ST_RSP: begin
              cnt_s = {CNT_W{1'b0}};
              if (!rx_r[7]) begin
                r1_s = rx_r;
                if (type_r == 2'd1) begin
                  state_s = ST_EXT;
                end else if (type_r == 2'd2 && rx_r != 8'h00) begin
                  err_s   = 3'd4;
                  state_s = ST_TAIL;
                end else if (type_r == 2'd2) begin
                  state_s = ST_TOKEN;
                end else begin
                  state_s = ST_TAIL;
                end
              end else if (cnt_r == CNT_W'(RSP_POLL - 1)) begin
                err_s   = 3'd1;
                state_s = ST_TAIL;
              end else begin
                cnt_s = cnt_r + CNT_W'(1);
              end
            end
            ST_EXT: begin
              rsp_data_s = {rsp_data[23:0], rx_r};
              if (cnt_r == CNT_W'(3)) begin
                state_s = ST_TAIL;
              end else begin
                state_s = ST_EXT;
              end
            end
            ST_TOKEN: begin
              if (rx_r == 8'hFE) begin
                state_s = ST_DATA;
                cnt_s   = {CNT_W{1'b0}};
              end else if (rx_r[7:4] == 4'h0) begin
                err_s   = 3'd3;
                state_s = ST_TAIL;
              end else if (cnt_r == CNT_W'(TOK_POLL - 1)) begin
                err_s   = 3'd2;
                state_s = ST_TAIL;
              end else begin
                state_s = ST_TOKEN;
              end
            end
            ST_DATA: begin
              rd_data_s  = rx_r;
              rd_valid_s = 1'b1;
              if (cnt_r == CNT_W'(511)) begin
                state_s = ST_CRC;
                cnt_s   = {CNT_W{1'b0}};
              end else begin
                state_s = ST_DATA;
              end
            end
            ST_CRC: begin
              if (cnt_r == CNT_W'(1)) begin
                state_s = ST_TAIL;
              end else begin
                state_s = ST_CRC;
              end
            end
            default: begin
              state_s = ST_IDLE;
              load_s  = 1'b0;
            end
          endcase
          // Deselect on the same falling edge that begins the closing 0xFF byte.
          if (state_s == ST_TAIL) begin
            cs_s = 1'b1;
          end else begin
            cs_s = sdCS;
          end
        end else begin
          state_s = state_r;
        end
      end
    endcase
  end

  // FSM state, counters and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      sdCS     <= 1'b1;
      err      <= 3'd0;
      r1       <= 8'hFF;
      rsp_data <= 32'h0000_0000;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      busy     <= busy_s;
      done     <= done_s;
      sdCS     <= cs_s;
      err      <= err_s;
      r1       <= r1_s;
      rsp_data <= rsp_data_s;
      rd_data  <= rd_data_s;
      rd_valid <= rd_valid_s;
    end
  end

  // Command fields held for the frame bytes sent after the first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_r  <= 6'd0;
      arg_r  <= 32'h0000_0000;
      crc_r  <= 7'd0;
      type_r <= 2'd0;
    end else if (latch_s) begin
      cmd_r  <= cmd;
      arg_r  <= arg;
      crc_r  <= crc;
      type_r <= rsp_type;
    end else begin
      cmd_r  <= cmd_r;
      arg_r  <= arg_r;
      crc_r  <= crc_r;
      type_r <= type_r;
    end
  end

endmodule

// File: tb/tb_sd_spi_host.sv
// tb_sd_spi_host -- directed/randomized bench for sd_spi_host with a
// byte-level SD card responder and a byte-stream reference model.
module tb_sd_spi_host;
  localparam int CLKDIV   = 3;
  localparam int RSP_POLL = 8;
  localparam int TOK_POLL = 16;
  localparam int CLK_P    = 10;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic [6:0]  crc;
  logic [1:0]  rsp_type;
  logic        busy, done, rd_valid, sdCS, sdSCLK, sdMOSI;
  logic        sdMISO = 1'b1;
  logic [2:0]  err;
  logic [7:0]  r1, rd_data;
  logic [31:0] rsp_data;

  sd_spi_host #(.CLKDIV(CLKDIV), .RSP_POLL(RSP_POLL), .TOK_POLL(TOK_POLL)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd), .arg(arg), .crc(crc),
    .rsp_type(rsp_type), .busy(busy), .done(done), .err(err), .r1(r1),
    .rsp_data(rsp_data), .rd_data(rd_data), .rd_valid(rd_valid), .sdCS(sdCS),
    .sdSCLK(sdSCLK), .sdMOSI(sdMOSI), .sdMISO(sdMISO)
  );

  always #(CLK_P/2) clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Card side: bytes the card returns once selected (0xFF past the end).
  logic [7:0] miso_mem [0:1023];
  int stream_len = 0;

  function automatic logic [7:0] sbyte(input int i);
    return (i < stream_len) ? miso_mem[i] : 8'hFF;
  endfunction

  task automatic push(input logic [7:0] b);
    miso_mem[stream_len] = b;
    stream_len++;
  endtask

  bit         in_frame = 0;
  int         s_idx, s_bit;
  logic [7:0] s_byte;
  always @(posedge sdCS or negedge sdCS or negedge sdSCLK) begin
    if (sdCS !== 1'b0) begin
      sdMISO = 1'b1;
      in_frame = 0;
    end else if (!in_frame) begin
      in_frame = 1; s_idx = 0; s_byte = sbyte(0); s_bit = 1; sdMISO = s_byte[7];
    end else if (s_bit == 8) begin
      s_idx++; s_byte = sbyte(s_idx); s_bit = 1; sdMISO = s_byte[7];
    end else begin
      sdMISO = s_byte[7 - s_bit]; s_bit++;
    end
  end

  // Host-side observation: MOSI bytes, SCLK edges and period, output strobes.
  logic [7:0] mosi_q [$];
  logic [7:0] rd_q [$];
  logic [7:0] m_sh;
  int m_cnt = 0, rises_lo = 0, rises_hi = 0, done_cnt = 0, done_busy_bad = 0;
  longint prev_t = 0, per_min = 64'd1000000, per_max = 0, dlt;
  bit have_prev = 0;
  always @(posedge sdSCLK or posedge sdCS) begin
    if (sdCS) begin
      m_cnt = 0; have_prev = 0;
      if (sdSCLK === 1'b1) rises_hi++;
    end else begin
      rises_lo++;
      m_sh = {m_sh[6:0], sdMOSI};
      m_cnt++;
      if (m_cnt == 8) begin mosi_q.push_back(m_sh); m_cnt = 0; end
      if (have_prev) begin
        dlt = $time - prev_t;
        if (dlt < per_min) per_min = dlt;
        if (dlt > per_max) per_max = dlt;
      end
      prev_t = $time; have_prev = 1;
    end
  end

  always @(negedge clk) begin
    if (rd_valid === 1'b1) rd_q.push_back(rd_data);
    if (done === 1'b1) begin
      done_cnt++;
      if (busy !== 1'b0) done_busy_bad++;
    end
  end

  // Reference model: walk the card byte stream by the protocol rules.
  logic [2:0]  exp_err;
  logic [7:0]  exp_r1;
  logic [31:0] exp_rsp;
  int          exp_nbytes;
  logic [7:0]  exp_data [$];

  task automatic model(input logic [1:0] ty);
    int i; bit found; logic [7:0] b;
    exp_err = 3'd0; exp_r1 = 8'hFF; exp_rsp = 32'h0; exp_data.delete();
    i = 6; found = 0;
    for (int p = 0; p < RSP_POLL; p++) begin
      b = sbyte(i); i++;
      if (b[7] == 1'b0) begin exp_r1 = b; found = 1; break; end
    end
    if (!found) exp_err = 3'd1;
    else if (ty == 2'd1) begin
      for (int j = 0; j < 4; j++) begin exp_rsp = {exp_rsp[23:0], sbyte(i)}; i++; end
    end else if (ty == 2'd2) begin
      if (exp_r1 != 8'h00) exp_err = 3'd4;
      else begin
        found = 0;
        for (int p = 0; p < TOK_POLL; p++) begin
          b = sbyte(i); i++;
          if (b == 8'hFE) begin found = 1; break; end
          else if (b[7:4] == 4'h0) begin exp_err = 3'd3; break; end
        end
        if (found) begin
          for (int j = 0; j < 512; j++) begin exp_data.push_back(sbyte(i)); i++; end
          i += 2;
        end else if (exp_err == 3'd0) exp_err = 3'd2;
      end
    end
    exp_nbytes = i;
  endtask

  task automatic begin_stream(input int delay, input logic [7:0] r);
    stream_len = 0;
    for (int j = 0; j < 6 + delay; j++) push(8'hFF);
    push(r);
  endtask

  task automatic run_op(input logic [5:0] c, input logic [31:0] a, input logic [6:0] k,
                        input logic [1:0] ty, input bit poke, input string tag);
    int d0, rl0, rh0, q0, m0, n, bad;
    logic [7:0] fr [0:5];
    fr[0] = {2'b01, c}; fr[1] = a[31:24]; fr[2] = a[23:16];
    fr[3] = a[15:8];    fr[4] = a[7:0];   fr[5] = {k, 1'b1};
    model(ty);
    @(negedge clk);
    d0 = done_cnt; rl0 = rises_lo; rh0 = rises_hi; q0 = rd_q.size(); m0 = mosi_q.size();
    cmd = c; arg = a; crc = k; rsp_type = ty; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      repeat (40) @(negedge clk);
      cmd = ~c; arg = ~a; rsp_type = 2'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (done !== 1'b1 && n < 40000) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, 64'(n < 40000), 64'd1);
    chk({tag, "_busy_with_done"}, 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    chk({tag, "_r1"}, 64'(r1), 64'(exp_r1));
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp_rsp));
    chk({tag, "_idle_pins"}, 64'({busy, sdCS, sdSCLK, sdMOSI}), 64'(4'b0101));
    chk({tag, "_sclk_sel"}, 64'(rises_lo - rl0), 64'(exp_nbytes * 8));
    chk({tag, "_sclk_tail"}, 64'(rises_hi - rh0), 64'd8);
    chk({tag, "_rd_count"}, 64'(rd_q.size() - q0), 64'(exp_data.size()));
    bad = 0;
    for (int j = 0; j < exp_data.size(); j++)
      if (q0 + j >= rd_q.size() || rd_q[q0 + j] !== exp_data[j]) bad++;
    chk({tag, "_rd_bytes_bad"}, 64'(bad), 64'd0);
    bad = 0;
    for (int j = 0; j < exp_nbytes; j++) begin
      if (m0 + j >= mosi_q.size()) bad++;
      else if (j < 6 && mosi_q[m0 + j] !== fr[j]) bad++;
      else if (j >= 6 && mosi_q[m0 + j] !== 8'hFF) bad++;
    end
    chk({tag, "_mosi_bytes_bad"}, 64'(bad), 64'd0);
  endtask

  initial begin
    int dly, t, cnt, rl0;
    logic [1:0] ty;
    reset = 1'b1; start = 1'b0; cmd = 6'd0; arg = 32'd0; crc = 7'd0; rsp_type = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_pins", 64'({sdCS, sdSCLK, sdMOSI}), 64'(3'b101));
    chk("rst_status", 64'({busy, done, rd_valid, err}), 64'd0);
    chk("rst_r1", 64'(r1), 64'hFF);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // CMD0, then CMD8 with an R7 tail.
    begin_stream($urandom_range(0, RSP_POLL - 1), 8'h01);
    run_op(6'd0, 32'h0, 7'h4A, 2'd0, 1'b0, "cmd0");
    begin_stream($urandom_range(0, RSP_POLL - 1), 8'h01);
    push(8'h00); push(8'h00); push(8'h01); push(8'hAA);
    run_op(6'd8, 32'h1AA, 7'h43, 2'd1, 1'b0, "cmd8");

    // Random non-read commands; delay RSP_POLL puts R1 past the poll window.
    for (int it = 0; it < 6; it++) begin
      ty = 2'($urandom_range(0, 2));
      if (ty == 2'd2) ty = 2'd3;
      dly = $urandom_range(0, RSP_POLL);
      begin_stream(dly, 8'($urandom_range(0, 127)));
      for (int j = 0; j < 4; j++) push(8'($urandom));
      run_op(6'($urandom), $urandom, 7'($urandom), ty, 1'b0, $sformatf("rand%0d", it));
    end

    // Full block read.
    begin_stream($urandom_range(0, RSP_POLL - 1), 8'h00);
    t = $urandom_range(0, TOK_POLL - 2);
    for (int j = 0; j < t; j++) push(8'hFF);
    push(8'hFE);
    for (int j = 0; j < 514; j++) push(8'($urandom));
    run_op(6'd17, $urandom, 7'($urandom), 2'd2, 1'b0, "cmd17");

    // Read errors: R1 nonzero, data error token, token timeout.
    begin_stream($urandom_range(0, RSP_POLL - 1), 8'($urandom_range(1, 127)));
    run_op(6'd17, $urandom, 7'($urandom), 2'd2, 1'b0, "rd_r1bad");
    begin_stream($urandom_range(0, RSP_POLL - 1), 8'h00);
    push(8'hFF); push(8'hFF); push({4'h0, 4'($urandom)});
    run_op(6'd17, $urandom, 7'($urandom), 2'd2, 1'b0, "rd_errtok");
    begin_stream($urandom_range(0, RSP_POLL - 1), 8'h00);
    run_op(6'd17, $urandom, 7'($urandom), 2'd2, 1'b0, "rd_toktmo");

    // No card answer at all.
    stream_len = 0;
    run_op(6'd55, 32'h0, 7'h32, 2'd0, 1'b0, "cmd55_tmo");
    chk("cmd55_err_const", 64'(err), 64'd1);
    chk("cmd55_r1_const", 64'(r1), 64'hFF);

    // Start pulsed mid-operation must be ignored.
    begin_stream($urandom_range(0, RSP_POLL - 1), 8'h01);
    run_op(6'd0, 32'h0, 7'h4A, 2'd0, 1'b1, "busy_start");

    chk("sclk_period_min", 64'(per_min), 64'(2 * CLKDIV * CLK_P));
    chk("sclk_period_max", 64'(per_max), 64'(2 * CLKDIV * CLK_P));

    // Reset in the middle of a data block.
    begin_stream(1, 8'h00);
    push(8'hFE);
    for (int j = 0; j < 514; j++) push(8'($urandom));
    @(negedge clk);
    cmd = 6'd17; arg = 32'h0; crc = 7'h0; rsp_type = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; t = 0;
    while (cnt < 100 && t < 20000) begin
      @(negedge clk); t++;
      if (rd_valid === 1'b1) cnt++;
    end
    chk("midrst_reached", 64'(cnt), 64'd100);
    #2 reset = 1'b1;
    #1;
    chk("midrst_pins", 64'({sdCS, sdSCLK, sdMOSI}), 64'(3'b101));
    chk("midrst_status", 64'({busy, done, rd_valid}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    rl0 = rises_lo + rises_hi;
    repeat (30) @(negedge clk);
    chk("midrst_no_tail", 64'(rises_lo + rises_hi - rl0), 64'd0);
    begin_stream($urandom_range(0, RSP_POLL - 1), 8'h01);
    run_op(6'd0, 32'h0, 7'h4A, 2'd0, 1'b0, "cmd0_after_rst");

    chk("done_while_busy", 64'(done_busy_bad), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
